// File: rtl/prbs_burst_ctrl.sv
// Round-robin sequencer for a shared PRBS31 generator: grants one of two requesters,
// loads its seed, then streams one generator bit per downstream handshake.
module prbs_burst_ctrl #(
  parameter int SEED_W = 31,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*SEED_W-1:0]   req_seed,
  input  logic [2*LEN_W-1:0]    req_len,
  input  logic                  abort,
  output logic                  gen_load,
  output logic [SEED_W-1:0]     gen_seed,
  output logic                  gen_step,
  input  logic                  gen_bit,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic                  out_owner,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  done_owner,
  output logic                  done_aborted,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic                owner;
  logic                aborted;
  logic [LEN_W-1:0]    count;
  logic [SEED_W-1:0]   seed;

  logic                grant;
  logic                accept;
  logic                handshake;
  logic [SEED_W-1:0]   sel_seed;
  logic [LEN_W-1:0]    sel_len;

  // Both valid: alternate away from the last owner; otherwise take whichever is valid.
  always_comb begin
    if (req_valid == 2'b11) grant = ~last_grant;
    else                    grant = ~req_valid[0];
  end

  assign sel_seed  = grant ? req_seed[2*SEED_W-1:SEED_W] : req_seed[SEED_W-1:0];
  assign sel_len   = grant ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
  assign accept    = (state == IDLE) && (|req_valid) && !rst_n;
  assign handshake = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      aborted    <= 1'b0;
      count      <= '0;
      seed       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          owner   <= grant;
          count   <= sel_len;
          aborted <= 1'b0;
          // An all-zero seed would lock the LFSR at zero forever.
          seed    <= (sel_seed == '0) ? {{(SEED_W-1){1'b0}}, 1'b1} : sel_seed;
        end
        LOAD: if (abort) aborted <= 1'b1;
        RUN: begin
          if (abort) aborted <= 1'b1;
          if (handshake) count <= count - LEN_W'(1);
        end
        DONE: last_grant <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 2'b00;
    gen_load     = 1'b0;
    gen_seed     = '0;
    gen_step     = 1'b0;
    out_valid    = 1'b0;
    out_bit      = 1'b0;
    out_owner    = 1'b0;
    done         = 1'b0;
    done_owner   = 1'b0;
    done_aborted = 1'b0;
    case (state)
      IDLE: if (accept) begin
        req_ready = grant ? 2'b10 : 2'b01;
        state_nxt = (sel_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        gen_load  = 1'b1;
        gen_seed  = seed;
        state_nxt = abort ? DONE : RUN;
      end
      RUN: begin
        out_bit   = gen_bit;
        out_owner = owner;
        // The abort cycle offers no bit, so nothing is transferred or stepped.
        if (abort) begin
          state_nxt = DONE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            gen_step = 1'b1;
            if (count == LEN_W'(1)) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done         = 1'b1;
        done_owner   = owner;
        done_aborted = aborted;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer and arbiter for the shared PRBS31 LFSR generator (x^31 + x^28 + 1, feedback bit0 <= s[27]^s[30], shift toward MSB). Two requesters each submit a seed and a burst length. The controller grants the generator round-robin, loads the seed, steps the generator once per accepted output bit, and streams the bits out with valid/ready and an owner tag. It sits between the requester logic and the LFSR core; it never computes LFSR state itself.

Parameters:
SEED_W, 31, generator state width; seed width per requester
LEN_W, 16, burst length counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the suffix, per codebase naming)
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept strobe (one-hot, one cycle)
req_seed  in  2*SEED_W  seeds; requester i at [i*SEED_W +: SEED_W]
req_len  in  2*LEN_W  burst lengths; requester i at [i*LEN_W +: LEN_W]
abort  in  1  terminate active burst
gen_load  out  1  load gen_seed into generator
gen_seed  out  SEED_W  seed to generator
gen_step  out  1  advance generator one shift
gen_bit  in  1  generator state MSB (s[30])
out_valid  out  1  stream bit valid
out_bit  out  1  stream bit
out_owner  out  1  requester index of current burst
out_ready  in  1  downstream accept
done  out  1  one-cycle burst-complete pulse
done_owner  out  1  owner of completed burst
done_aborted  out  1  qualifies done: burst ended by abort
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=1 at clk edge): state IDLE, last_grant=1, count=0, latched seed=0, all outputs 0. Reset mid-burst drops the burst silently, with no done pulse.
- Generator contract: gen_load has priority over gen_step. Generator state updates on the edge after the strobe. gen_bit is combinational from generator state.
- FSM IDLE -> LOAD -> RUN -> DONE -> IDLE. A zero-length request goes IDLE -> DONE.
- IDLE:
  - If any req_valid, grant g. If both are valid, g = ~last_grant; otherwise the single valid one.
  - req_ready[g]=1 this cycle.
  - Latch seed, len, owner=g. A zero seed is replaced by 1 (avoids lockup).
  - len==0 -> DONE; else -> LOAD.
- LOAD: gen_load=1 and gen_seed=latched seed for exactly one cycle -> RUN. Timing: accept at cycle T, load at T+1, first out_valid at T+2.
- RUN:
  - out_valid=1, out_bit=gen_bit, out_owner=owner.
  - On out_valid&out_ready: gen_step=1 in the same cycle and count decrements.
  - On the handshake with count==1 -> DONE.
  - With out_ready=0: gen_step=0 and out_bit is held stable.
- abort in LOAD or RUN -> DONE next cycle with done_aborted=1.
  - No gen_step is issued in the abort cycle, even if out_ready=1; that bit counts as not transferred.
  - abort in IDLE or DONE is ignored.
- DONE: done=1, done_owner=owner, done_aborted per cause, last_grant<=owner -> IDLE. No new grant is issued in a DONE cycle.
- req_ready is never asserted outside IDLE. A requester holds req_valid and its data until accepted.
- out_valid is 0 in IDLE, LOAD and DONE. Exactly len handshakes occur per non-aborted burst.
- Count width is LEN_W. The maximum length 2^LEN_W-1 must not wrap.

Test Plan:
- Seed 31'h4000_0000, len 4, req 0 only, out_ready=1 -> req_ready[0] at T, gen_load at T+1, out_bit 1,0,0,0 at T+2..T+5, done at T+6 with done_owner=0 and done_aborted=0.
- Both req_valid=1 right after reset, len 2 each -> requester 0 served first, then requester 1. Then req 1 alone followed by both valid -> requester 0 granted (alternation holds).
- Seed 0 -> gen_seed=31'h0000_0001 during LOAD; stream starts 0,0,...
- len 3, out_ready=0 for 3 cycles after the first bit -> out_valid held, out_bit stable, gen_step=0 throughout; exactly 3 handshakes; done after the third.
- len 0 -> req_ready, then done the next cycle; no gen_load and no out_valid.
- len 10, abort after 4 handshakes -> done with done_aborted=1 one cycle later, 4 gen_step pulses total. rst_n asserted mid-burst -> all outputs 0 next cycle and no done pulse.
